vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the 1280x1024@60 display path (108 MHz pixel clock).
//  Drives VGA_HORZ_COORD/VGA_VERT_COORD to the waveform/background pixel renderers.
//  Takes back their combined 4:4:4 RGB after a fixed renderer latency.
//  Emits the pin-level HS/VS/RGB with sync, blanking and colour cycle-aligned.
// PARAMETERS
//  H_VIS      1280  visible pixels per line
//  H_FP       48    horizontal front porch (clocks)
//  H_SYNC     112   horizontal sync width (clocks)
//  H_BP       248   horizontal back porch; H_TOTAL = sum = 1688
//  V_VIS      1024  visible lines per frame
//  V_FP       1     vertical front porch (lines)
//  V_SYNC     3     vertical sync width (lines)
//  V_BP       38    vertical back porch; V_TOTAL = sum = 1066
//  SYNC_POL   1     active level of HS/VS (1 = positive, the 1280x1024 standard)
//  PIPE_DELAY 1     renderer latency in clocks from coords to pixel_*; range 0..7
// PORTS
//  clk_vga         in   1   pixel clock, 108 MHz
//  rst_n           in   1   asynchronous active-low reset
//  pixel_red       in   4   renderer red for coords issued PIPE_DELAY clocks earlier
//  pixel_green     in   4   renderer green, same alignment
//  pixel_blue      in   4   renderer blue, same alignment
//  VGA_HORZ_COORD  out  12  raster column counter, 0..H_TOTAL-1
//  VGA_VERT_COORD  out  12  raster line counter, 0..V_TOTAL-1
//  video_active    out  1   1 when VGA_HORZ_COORD<H_VIS && VGA_VERT_COORD<V_VIS; aligned with coords
//  frame_start     out  1   1-clock pulse while coords == (0,0)
//  VGA_HS          out  1   horizontal sync to pin
//  VGA_VS          out  1   vertical sync to pin
//  VGA_RED         out  4   red to pin; 0 during blanking
//  VGA_GREEN       out  4   green to pin; 0 during blanking
//  VGA_BLUE        out  4   blue to pin; 0 during blanking
// BEHAVIOUR
//  Reset (async assert, sync release on clk_vga):
//   - coords = (H_TOTAL-1, V_TOTAL-1) = (1687, 1065); video_active = 0; frame_start = 0.
//   - VGA_HS/VGA_VS = ~SYNC_POL; VGA_RED/GREEN/BLUE = 0; all delay-line stages cleared to the same inactive values.
//  Counters, one increment per clock:
//   - H wraps H_TOTAL-1 -> 0.
//   - V increments only when H wraps; V wraps V_TOTAL-1 -> 0 on the same edge that H wraps.
//   - First edge after release therefore gives coords (0,0) with frame_start = 1.
//  Stage-0 decode, registered, aligned with the coords:
//   - video_active and frame_start as defined under PORTS.
//   - hs0 = SYNC_POL when H in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [1328,1439].
//   - vs0 = SYNC_POL when V in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [1025,1027], for whole lines.
//  Alignment pipeline:
//   - hs0, vs0 and active0 pass through a PIPE_DELAY-deep shift register (PIPE_DELAY=0 -> direct).
//   - Output register on every edge:
//     VGA_HS <= hs_d; VGA_VS <= vs_d;
//     VGA_RED/GREEN/BLUE <= active_d ? pixel_* : 4'h0.
//   - Pin latency from a coordinate to its sync/RGB = PIPE_DELAY+1 clocks.
//   - pixel_* is ignored whenever active_d = 0; renderers may drive garbage in blanking.
//  Coordinates are raw counters; renderers gate on video_active, since X reaches 1687 in blanking.
//  No handshake, no stall: free-running once out of reset.
//  Reset mid-frame: outputs go to reset values immediately (async); the frame restarts at (0,0) on the first edge after release.
//  Counters are 12-bit; H_TOTAL and V_TOTAL must be <= 4096 (elaboration check).
// TESTING
//  1. Release reset -> 1st edge: coords (0,0), frame_start=1, video_active=1; 2nd edge: (1,0), frame_start=0.
//  2. Count clocks between frame_start pulses -> exactly 1688*1066 = 1799408; no other pulses.
//  3. PIPE_DELAY=1, line 0 -> VGA_HS=1 for clocks 1330..1441 after line start (112 wide); VGA_VS high for lines 1025..1027 only.
//  4. Drive pixel_*=F,A,5 constantly -> pins show F/A/5 for cycles 2..1281 of visible lines; 0 at X>=1280 and for lines 1024..1065.
//  5. Renderer echoes pixel_red = X[3:0] delayed 1 clk -> VGA_RED equals (X mod 16) for that pixel 2 clks after X issued, all 1280 cols.
//  6. Assert rst_n low at coords (700,500) for 3 clks -> HS/VS = ~SYNC_POL, RGB=0 at once; after release coords restart at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 1280x1024@60 raster counters with sync, blanking and colour aligned to the renderer latency
module vga_timing_gen #(
    parameter int H_VIS      = 1280,
    parameter int H_FP       = 48,
    parameter int H_SYNC     = 112,
    parameter int H_BP       = 248,
    parameter int V_VIS      = 1024,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 38,
    parameter bit SYNC_POL   = 1'b1,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    input  logic [3:0]  pixel_red,
    input  logic [3:0]  pixel_green,
    input  logic [3:0]  pixel_blue,
    output logic [11:0] VGA_HORZ_COORD,
    output logic [11:0] VGA_VERT_COORD,
    output logic        video_active,
    output logic        frame_start,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_RED,
    output logic [3:0]  VGA_GREEN,
    output logic [3:0]  VGA_BLUE
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_MAX = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_MAX = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_C = 12'(H_VIS);
    localparam logic [11:0] V_VIS_C = 12'(V_VIS);
    localparam logic [11:0] HS_LO = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_HI = 12'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_LO = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_HI = 12'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [2:0] INACT = {~SYNC_POL, ~SYNC_POL, 1'b0};

    if (H_TOTAL > 4096 || V_TOTAL > 4096 || PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_param_chk
        $error("vga_timing_gen: totals must be <= 4096 and PIPE_DELAY in 0..7");
    end

    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        hs0;
    logic        vs0;
    logic [2:0]  stage0;
    logic [2:0]  stage_d;

    always_comb begin
        h_nxt = VGA_HORZ_COORD == H_MAX ? 12'd0 : VGA_HORZ_COORD + 12'd1;
        v_nxt = VGA_HORZ_COORD != H_MAX ? VGA_VERT_COORD :
                VGA_VERT_COORD == V_MAX ? 12'd0 : VGA_VERT_COORD + 12'd1;
    end

    // Decode from the next coordinates so every stage-0 flag lands on the same edge as its coords
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            VGA_HORZ_COORD <= H_MAX;
            VGA_VERT_COORD <= V_MAX;
            video_active   <= 1'b0;
            frame_start    <= 1'b0;
            hs0            <= ~SYNC_POL;
            vs0            <= ~SYNC_POL;
        end else begin
            VGA_HORZ_COORD <= h_nxt;
            VGA_VERT_COORD <= v_nxt;
            video_active   <= h_nxt < H_VIS_C && v_nxt < V_VIS_C;
            frame_start    <= h_nxt == 12'd0 && v_nxt == 12'd0;
            hs0            <= (h_nxt >= HS_LO && h_nxt <= HS_HI) ? SYNC_POL : ~SYNC_POL;
            vs0            <= (v_nxt >= VS_LO && v_nxt <= VS_HI) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign stage0 = {hs0, vs0, video_active};

    if (PIPE_DELAY == 0) begin : g_direct
        assign stage_d = stage0;
    end else begin : g_pipe
        logic [PIPE_DELAY-1:0][2:0] sr;
        always_ff @(posedge clk_vga or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_DELAY; i++) sr[i] <= INACT;
            end else begin
                sr[0] <= stage0;
                for (int i = 1; i < PIPE_DELAY; i++) sr[i] <= sr[i-1];
            end
        end
        assign stage_d = sr[PIPE_DELAY-1];
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            VGA_HS    <= ~SYNC_POL;
            VGA_VS    <= ~SYNC_POL;
            VGA_RED   <= 4'h0;
            VGA_GREEN <= 4'h0;
            VGA_BLUE  <= 4'h0;
        end else begin
            VGA_HS    <= stage_d[2];
            VGA_VS    <= stage_d[1];
            VGA_RED   <= stage_d[0] ? pixel_red : 4'h0;
            VGA_GREEN <= stage_d[0] ? pixel_green : 4'h0;
            VGA_BLUE  <= stage_d[0] ? pixel_blue : 4'h0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size instance checked against a directed vector table,
// plus a shrunken raster (PIPE_DELAY=2) checked every cycle across frame wraps and a mid-frame reset
module tb_vga_timing_gen;
    typedef struct {
        int          cnt;
        logic [11:0] h;
        logic [11:0] v;
        logic        act;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } vec_t;

    logic        clk_vga = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rst_s_n = 1'b0;
    logic [3:0]  pr, pg, pb;
    logic [11:0] hc, vc;
    logic        act, fs, hs, vs;
    logic [3:0]  r, g, b;
    logic [3:0]  spr, spg, spb;
    logic [11:0] shc, svc;
    logic        sact, sfs, shs, svs;
    logic [3:0]  sr, sg, sb;
    logic [11:0] rd1_h, rd1_v, rd2_h, rd2_v;
    int          passed = 0;
    int          total  = 0;

    always #5 clk_vga = ~clk_vga;

    vga_timing_gen dut (
        .clk_vga(clk_vga), .rst_n(rst_n),
        .pixel_red(pr), .pixel_green(pg), .pixel_blue(pb),
        .VGA_HORZ_COORD(hc), .VGA_VERT_COORD(vc),
        .video_active(act), .frame_start(fs),
        .VGA_HS(hs), .VGA_VS(vs),
        .VGA_RED(r), .VGA_GREEN(g), .VGA_BLUE(b)
    );

    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .PIPE_DELAY(2)
    ) dut_s (
        .clk_vga(clk_vga), .rst_n(rst_s_n),
        .pixel_red(spr), .pixel_green(spg), .pixel_blue(spb),
        .VGA_HORZ_COORD(shc), .VGA_VERT_COORD(svc),
        .video_active(sact), .frame_start(sfs),
        .VGA_HS(shs), .VGA_VS(svs),
        .VGA_RED(sr), .VGA_GREEN(sg), .VGA_BLUE(sb)
    );

    // Renderer for the small raster: two-clock echo of its coordinates
    always @(posedge clk_vga) begin
        rd1_h <= shc;
        rd1_v <= svc;
        rd2_h <= rd1_h;
        rd2_v <= rd1_v;
    end
    assign spr = rd2_h[3:0];
    assign spg = rd2_v[3:0];
    assign spb = ~rd2_h[3:0];

    task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [39:0] small_got();
        return {shc, svc, sact, sfs, shs, svs, sr, sg, sb};
    endfunction

    // Expected small-raster outputs n edges after reset release (25 x 11 raster, pin latency 3)
    function automatic logic [39:0] small_exp(input int n);
        int          i = n - 1;
        int          k = n - 4;
        logic [11:0] h = 12'(i % 25);
        logic [11:0] v = 12'((i / 25) % 11);
        logic [11:0] x = 12'(k % 25);
        logic [11:0] y = 12'((k / 25) % 11);
        logic        e_act = h < 12'd16 && v < 12'd6;
        logic        e_fs = h == 12'd0 && v == 12'd0;
        logic        e_hs = 1'b0;
        logic        e_vs = 1'b0;
        logic [11:0] rgb = 12'h000;
        if (n >= 4) begin
            e_hs = x >= 12'd18 && x <= 12'd20;
            e_vs = y >= 12'd7 && y <= 12'd8;
            if (x < 12'd16 && y < 12'd6) rgb = {x[3:0], y[3:0], ~x[3:0]};
        end
        return {h, v, e_act, e_fs, e_hs, e_vs, rgb};
    endfunction

    initial begin
        vec_t tbl [15];
        int   idx = 0;
        logic found = 1'b0;
        pr = 4'hF;
        pg = 4'hA;
        pb = 4'h5;
        tbl = '{
            '{1,    12'd0,    12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{2,    12'd1,    12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{3,    12'd2,    12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hA, 4'h5},
            '{1280, 12'd1279, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hA, 4'h5},
            '{1281, 12'd1280, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hA, 4'h5},
            '{1282, 12'd1281, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hA, 4'h5},
            '{1283, 12'd1282, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1330, 12'd1329, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1331, 12'd1330, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1442, 12'd1441, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1443, 12'd1442, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1688, 12'd1687, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1689, 12'd0,    12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1690, 12'd1,    12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0},
            '{1691, 12'd2,    12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hA, 4'h5}
        };
        repeat (3) @(negedge clk_vga);
        chk("rst_hc", 40'(hc), 40'd1687);
        chk("rst_vc", 40'(vc), 40'd1065);
        chk("rst_act_fs_hs_vs", 40'({act, fs, hs, vs}), 40'd0);
        chk("rst_rgb", 40'({r, g, b}), 40'd0);
        chk("rst_small", small_got(), {12'd24, 12'd10, 16'h0000});
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        for (int cnt = 1; cnt <= 1700; cnt++) begin
            @(negedge clk_vga);
            chk("small_run", small_got(), small_exp(cnt));
            if (cnt > 1) chk("dflt_fs_single", 40'(fs), 40'd0);
            if (idx < 15 && tbl[idx].cnt == cnt) begin
                chk("tbl_hc", 40'(hc), 40'(tbl[idx].h));
                chk("tbl_vc", 40'(vc), 40'(tbl[idx].v));
                chk("tbl_act", 40'(act), 40'(tbl[idx].act));
                chk("tbl_fs", 40'(fs), 40'(tbl[idx].fs));
                chk("tbl_hs", 40'(hs), 40'(tbl[idx].hs));
                chk("tbl_vs", 40'(vs), 40'(tbl[idx].vs));
                chk("tbl_rgb", 40'({r, g, b}), 40'({tbl[idx].r, tbl[idx].g, tbl[idx].b}));
                idx++;
            end
        end
        chk("tbl_all_applied", 40'(idx), 40'd15);
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk_vga);
            if (shc == 12'd10 && svc == 12'd3) found = 1'b1;
        end
        chk("find_10_3", 40'(found), 40'd1);
        rst_s_n = 1'b0;
        #1;
        chk("async_rst", small_got(), {12'd24, 12'd10, 16'h0000});
        repeat (3) @(negedge clk_vga);
        chk("held_rst", small_got(), {12'd24, 12'd10, 16'h0000});
        rst_s_n = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk_vga);
            chk("small_restart", small_got(), small_exp(n));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
